// File: rtl/cf_pkg.sv
// Shared encodings for the 1052/2150 adapter sequencers.
// Holds the FSM states, the op kinds and the cfdecode o_fd_out bit positions.
package cf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_PICK,
        ST_MOTION,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_PRINT,
        OP_SPACE,
        OP_CRLF,
        OP_LC,
        OP_UC,
        OP_NULL
    } op_kind_t;

    localparam int FD_SPACE = 4;
    localparam int FD_CRLF  = 3;
    localparam int FD_READY = 2;
    localparam int FD_LC    = 1;
    localparam int FD_UC    = 0;

    // The ready bit is never a pick request, so a function char showing only ready is a null op.
    function automatic op_kind_t decode_op(input logic func, input logic [4:0] fd);
        if (!func)             return OP_PRINT;
        else if (fd[FD_CRLF])  return OP_CRLF;
        else if (fd[FD_SPACE]) return OP_SPACE;
        else if (fd[FD_LC])    return OP_LC;
        else if (fd[FD_UC])    return OP_UC;
        else                   return OP_NULL;
    endfunction

    // One-hot magnet vector: bit 0 print, 1 space, 2 crlf, 3 lc, 4 uc.
    function automatic logic [4:0] magnet_of(input op_kind_t kind);
        logic [4:0] m;
        m = '0;
        case (kind)
            OP_PRINT: m[0] = 1'b1;
            OP_SPACE: m[1] = 1'b1;
            OP_CRLF:  m[2] = 1'b1;
            OP_LC:    m[3] = 1'b1;
            OP_UC:    m[4] = 1'b1;
            default:  m    = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cf_down_counter.sv
// Loadable down counter with a zero flag; stops at zero.
// Generic so keyboard and strobe timers can share it.
module cf_down_counter #(
    parameter int CW = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/cf_magnet_seq.sv
// Print-cycle sequencer: strobes cfdecode, fires one magnet for a timed pick,
// then holds busy through the mechanical motion; owns the CR and case latches.
module cf_magnet_seq
    import cf_pkg::*;
#(
    parameter int PICK_CYCLES  = 16,
    parameter int CHAR_CYCLES  = 64,
    parameter int CRLF_CYCLES  = 512,
    parameter int SHIFT_CYCLES = 128,
    parameter int CW           = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_cr_req,
    input  logic       i_function,
    input  logic [4:0] i_fd_out,
    output logic       o_cycle_time,
    output logic       o_cr_latch,
    output logic       o_case_latch,
    output logic       o_print_mag,
    output logic       o_space_mag,
    output logic       o_crlf_mag,
    output logic       o_lc_mag,
    output logic       o_uc_mag,
    output logic       o_busy,
    output logic       o_done
);

    if (PICK_CYCLES < 1 || CHAR_CYCLES <= PICK_CYCLES || CRLF_CYCLES <= PICK_CYCLES ||
        SHIFT_CYCLES <= PICK_CYCLES) begin : g_bad_pick
        $error("cf_magnet_seq: every op length must exceed PICK_CYCLES, which must be >= 1");
    end
    if (CHAR_CYCLES > (1 << CW) || CRLF_CYCLES > (1 << CW) || SHIFT_CYCLES > (1 << CW)) begin : g_bad_cw
        $error("cf_magnet_seq: CW too narrow for the op lengths");
    end

    localparam logic [CW-1:0] PICK_LOAD  = CW'(PICK_CYCLES - 1);
    localparam logic [CW-1:0] CHAR_LOAD  = CW'(CHAR_CYCLES - PICK_CYCLES - 1);
    localparam logic [CW-1:0] CRLF_LOAD  = CW'(CRLF_CYCLES - PICK_CYCLES - 1);
    localparam logic [CW-1:0] SHIFT_LOAD = CW'(SHIFT_CYCLES - PICK_CYCLES - 1);

    state_t        r_state;
    op_kind_t      r_kind;
    logic [4:0]    r_mag;
    logic          r_busy;
    logic          r_done;
    logic          r_cr_latch;
    logic          r_case_latch;
    logic          w_zero;
    logic          w_load;
    logic          w_en;
    logic [CW-1:0] w_load_val;
    logic [CW-1:0] w_motion_load;

    always_comb begin
        case (r_kind)
            OP_CRLF:      w_motion_load = CRLF_LOAD;
            OP_LC, OP_UC: w_motion_load = SHIFT_LOAD;
            default:      w_motion_load = CHAR_LOAD;
        endcase
    end

    assign w_load     = (r_state == ST_DECODE) || ((r_state == ST_PICK) && w_zero);
    assign w_load_val = (r_state == ST_DECODE) ? PICK_LOAD : w_motion_load;
    assign w_en       = (r_state == ST_PICK) || (r_state == ST_MOTION);

    cf_down_counter #(.CW(CW)) u_op_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    // A new CR request always beats the end-of-op clear, so a CR typed during DONE is never lost.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_kind       <= OP_NULL;
            r_mag        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cr_latch   <= 1'b0;
            r_case_latch <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_cr_req) begin
                r_cr_latch <= 1'b1;
            end else if ((r_state == ST_DONE) && (r_kind == OP_CRLF)) begin
                r_cr_latch <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start || r_cr_latch) begin
                        r_state <= ST_DECODE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_kind  <= decode_op(i_function, i_fd_out);
                    r_mag   <= magnet_of(decode_op(i_function, i_fd_out));
                    r_state <= ST_PICK;
                end
                ST_PICK: begin
                    if (w_zero) begin
                        r_mag   <= '0;
                        r_state <= ST_MOTION;
                    end
                end
                ST_MOTION: begin
                    if (w_zero) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (r_kind == OP_LC) begin
                        r_case_latch <= 1'b0;
                    end else if (r_kind == OP_UC) begin
                        r_case_latch <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cycle_time = (r_state == ST_DECODE);
    assign o_cr_latch   = r_cr_latch;
    assign o_case_latch = r_case_latch;
    assign o_print_mag  = r_mag[0];
    assign o_space_mag  = r_mag[1];
    assign o_crlf_mag   = r_mag[2];
    assign o_lc_mag     = r_mag[3];
    assign o_uc_mag     = r_mag[4];
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
